// File: rtl/mips_trace_pkg.sv
// Shared types and default configuration for the MIPS datapath trace buffer.
// Contents: capture state enum and default parameter constants.
package mips_trace_pkg;

   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_CHANNELS  = 4;
   localparam int unsigned DEF_DEPTH     = 16;
   localparam int unsigned DEF_POST_TRIG = 8;

   // Capture sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_POST = 2'd2,
      ST_DONE = 2'd3
   } trace_state_e;

endpackage : mips_trace_pkg

// File: rtl/trace_ram.sv
// Sample storage for the trace buffer: DEPTH x DW, one synchronous write port,
// one combinational read port. Contents are not reset.
// Ports:
//   clk        - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address
//   rd_data_o  - read data (combinational from rd_addr_i)
module trace_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned DW    = 128
) (
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [DW-1:0]            wr_data_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [DW-1:0]            rd_data_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Asynchronous read port
   assign rd_data_o = mem_q[rd_addr_i];

endmodule : trace_ram

// File: rtl/mips_trace_buffer.sv
// Pre/post-trigger trace buffer for observing MIPS datapath buses.
// Captures CHANNELS x WIDTH samples into a circular buffer while armed, keeps
// POST_TRIG samples after the trigger, then drains oldest-first over a
// valid/ready readout port.
// Optional feature: define TRACE_CHANGE_ONLY_EN to store a sample only when it
// differs from the last stored one (the first sample and the trigger sample are
// always stored).
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   ch_data     - sampled buses, channel k at [k*WIDTH +: WIDTH]
//   arm         - start pre-trigger capture (IDLE only)
//   trig        - trigger event (PRE only)
//   rd_ready    - readout consumer ready
//   rd_valid    - rd_data holds a stored sample
//   rd_data     - readout sample, zero when rd_valid is low
//   rd_last     - current rd_data is the final entry
//   busy        - capture in progress (PRE or POST)
//   count       - entries held, saturating at DEPTH
module mips_trace_buffer
   import mips_trace_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned CHANNELS  = DEF_CHANNELS,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned POST_TRIG = DEF_POST_TRIG
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] ch_data,
   input  logic                      arm,
   input  logic                      trig,
   input  logic                      rd_ready,
   output logic                      rd_valid,
   output logic [CHANNELS*WIDTH-1:0] rd_data,
   output logic                      rd_last,
   output logic                      busy,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = CHANNELS * WIDTH;

   trace_state_e  state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] post_q, post_d;

   logic          capture_c;
   logic          store_c;
   logic          wr_en_c;
   logic          hs_c;
   logic [AW-1:0] rd_addr_c;
   logic [DW-1:0] ram_rdata;

   assign capture_c = (state_q == ST_PRE) || (state_q == ST_POST);
   assign hs_c      = (state_q == ST_DONE) && (count_q != '0) && rd_ready;

`ifdef TRACE_CHANGE_ONLY_EN
   logic [DW-1:0] last_q;

   // Store on first sample, on any change, and always on the trigger cycle
   assign store_c = (count_q == '0) || (ch_data != last_q) ||
                    ((state_q == ST_PRE) && trig);

   // Copy of the most recently stored sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= '0;
      end else if (wr_en_c) begin
         last_q <= ch_data;
      end
   end
`else
   assign store_c = 1'b1;
`endif

   assign wr_en_c = capture_c && store_c;

   // Oldest entry sits count entries behind the write pointer; a full buffer
   // (count == DEPTH) wraps to the write pointer itself.
   assign rd_addr_c = wptr_q - count_q[AW-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arm) state_d = ST_PRE;
         end
         ST_PRE: begin
            if (trig) state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
         end
         ST_POST: begin
            if (post_q == AW'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (count_q == '0) begin
               state_d = ST_IDLE;
            end else if (hs_c && (count_q == CW'(1))) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state: write pointer, fill count, post-trigger countdown
   always_comb begin
      wptr_d  = wptr_q;
      count_d = count_q;
      post_d  = post_q;

      if ((state_q == ST_IDLE) && arm) begin
         wptr_d  = '0;
         count_d = '0;
      end

      if (wr_en_c) begin
         wptr_d = wptr_q + AW'(1);
         if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
      end

      // Countdown runs on clock cycles, independent of whether a sample is stored
      if ((state_q == ST_PRE) && trig) begin
         post_d = AW'(POST_TRIG);
      end else if (state_q == ST_POST) begin
         post_d = post_q - AW'(1);
      end

      if (hs_c) count_d = count_q - CW'(1);
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         count_q <= '0;
         post_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         count_q <= count_d;
         post_q  <= post_d;
      end
   end

   // Outputs decoded from registered state only, so reset clears them at once
   always_comb begin
      busy     = capture_c;
      rd_valid = (state_q == ST_DONE) && (count_q != '0);
      rd_last  = rd_valid && (count_q == CW'(1));
      rd_data  = rd_valid ? ram_rdata : '0;
   end

   assign count = count_q;

   trace_ram #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en_c),
      .wr_addr_i (wptr_q),
      .wr_data_i (ch_data),
      .rd_addr_i (rd_addr_c),
      .rd_data_o (ram_rdata)
   );

endmodule : mips_trace_buffer

// File: tb/tb_mips_trace_buffer.sv
// Directed testbench for mips_trace_buffer (default parameters: DEPTH=16,
// POST_TRIG=8). Sample i of a capture carries i in the low bits of each
// channel plus the channel number in bits [23:16].
module tb_mips_trace_buffer;

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned CHANNELS = 4;
   localparam int unsigned DW       = WIDTH * CHANNELS;
   localparam int unsigned CW       = 5;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] ch_data;
   logic          arm;
   logic          trig;
   logic          rd_ready;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_last;
   logic          busy;
   logic [CW-1:0] count;

   int checks   = 0;
   int failures = 0;

   mips_trace_buffer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch_data  (ch_data),
      .arm      (arm),
      .trig     (trig),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_last  (rd_last),
      .busy     (busy),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int v);
      logic [DW-1:0] r;
      for (int k = 0; k < int'(CHANNELS); k++) begin
         r[k*WIDTH +: WIDTH] = WIDTH'(v) + WIDTH'(k << 16);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Arm, then feed samples 0..trig_idx+8 with trig on sample trig_idx
   task automatic run_capture(input int trig_idx);
      rd_ready = 1'b0;
      arm      = 1'b1;
      ch_data  = mk(500);
      tick();
      arm = 1'b0;
      for (int i = 0; i <= trig_idx + 8; i++) begin
         ch_data = mk(i);
         trig    = (i == trig_idx);
         tick();
      end
      trig = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; arm = 1'b0; trig = 1'b0; rd_ready = 1'b0; ch_data = '0;
      #2 rst_n = 1'b0;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
          count !== CW'(0) || rd_data !== '0) begin
         failures++;
         $display("FAIL reset: busy=%b valid=%b last=%b count=%0d data=%h want 0",
                  busy, rd_valid, rd_last, count, rd_data);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_capture();
      arm = 1'b1; tick(); arm = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL basic_busy: got %b want 1", busy);
      end
      ch_data = mk(0); tick();
      // resume the regular sequence from sample 1
      for (int i = 1; i <= 28; i++) begin
         ch_data = mk(i); trig = (i == 20); tick();
      end
      trig = 1'b0;
      checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b1 || count !== CW'(16)) begin
         failures++;
         $display("FAIL basic_done: busy=%b valid=%b count=%0d want 0 1 16", busy, rd_valid, count);
      end
      rd_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== mk(13 + j) || rd_last !== (j == 15)) begin
            failures++;
            $display("FAIL basic_read[%0d]: valid=%b last=%b data=%h want %h", j, rd_valid,
                     rd_last, rd_data, mk(13 + j));
         end
         tick();
      end
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || count !== CW'(0) || rd_data !== '0) begin
         failures++;
         $display("FAIL basic_drained: valid=%b count=%0d data=%h want 0 0 0", rd_valid, count, rd_data);
      end
   endtask

   task automatic test_early_trigger();
      run_capture(2);
      checks++;
      if (count !== CW'(11)) begin
         failures++; $display("FAIL early_count: got %0d want 11", count);
      end
      rd_ready = 1'b1;
      for (int j = 0; j < 11; j++) begin
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== mk(j) || rd_last !== (j == 10)) begin
            failures++;
            $display("FAIL early_read[%0d]: valid=%b last=%b data=%h want %h", j, rd_valid,
                     rd_last, rd_data, mk(j));
         end
         tick();
      end
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || count !== CW'(0)) begin
         failures++; $display("FAIL early_drained: valid=%b count=%0d want 0 0", rd_valid, count);
      end
   endtask

   task automatic test_backpressure();
      int exp_idx;
      run_capture(5);   // samples 0..13
      exp_idx = 0;
      for (int cyc = 0; cyc < 60 && exp_idx < 14; cyc++) begin
         rd_ready = ((cyc % 3) != 1);
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== mk(exp_idx) || rd_last !== (exp_idx == 13)) begin
            failures++;
            $display("FAIL bp_read[%0d]: valid=%b last=%b data=%h want %h", exp_idx, rd_valid,
                     rd_last, rd_data, mk(exp_idx));
         end
         if (rd_ready) exp_idx++;
         tick();
      end
      rd_ready = 1'b0;
      checks++;
      if (exp_idx != 14 || rd_valid !== 1'b0 || count !== CW'(0)) begin
         failures++;
         $display("FAIL bp_end: delivered=%0d valid=%b count=%0d want 14 0 0", exp_idx, rd_valid, count);
      end
   endtask

   task automatic test_reset_mid();
      arm = 1'b1; tick(); arm = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ch_data = mk(i); trig = (i == 5); tick();
      end
      trig = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL mid_busy: got %b want 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || count !== CW'(0) || rd_valid !== 1'b0 || rd_data !== '0) begin
         failures++;
         $display("FAIL mid_reset: busy=%b count=%0d valid=%b data=%h want 0", busy, count,
                  rd_valid, rd_data);
      end
      tick();
      rst_n = 1'b1;
      tick();
      run_capture(1);   // samples 0..9
      checks++;
      if (count !== CW'(10) || rd_data !== mk(0)) begin
         failures++;
         $display("FAIL mid_rearm: count=%0d data=%h want 10 %h", count, rd_data, mk(0));
      end
      rd_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         checks++;
         if (rd_data !== mk(j) || rd_last !== (j == 9)) begin
            failures++;
            $display("FAIL mid_read[%0d]: last=%b data=%h want %h", j, rd_last, rd_data, mk(j));
         end
         tick();
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_ignored();
      run_capture(15);  // samples 0..23, oldest kept is 8
      arm = 1'b1; tick(); tick(); arm = 1'b0;
      checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b1 || count !== CW'(16) || rd_data !== mk(8)) begin
         failures++;
         $display("FAIL ign_arm_done: busy=%b valid=%b count=%0d data=%h want 0 1 16 %h",
                  busy, rd_valid, count, rd_data, mk(8));
      end
      rd_ready = 1'b1;
      for (int j = 0; j < 16; j++) tick();
      rd_ready = 1'b0;
      trig = 1'b1; tick(); tick(); tick(); trig = 1'b0;
      checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b0 || count !== CW'(0)) begin
         failures++;
         $display("FAIL ign_trig_idle: busy=%b valid=%b count=%0d want 0 0 0", busy, rd_valid, count);
      end
   endtask

   task automatic test_constant_data();
      logic [DW-1:0] cval;
      cval = {CHANNELS{32'h0000_00A5}};
      arm = 1'b1; tick(); arm = 1'b0;
      ch_data = cval;
      for (int i = 0; i < 19; i++) begin
         trig = (i == 10); tick();
      end
      trig = 1'b0;
`ifdef TRACE_CHANGE_ONLY_EN
      checks++;
      if (count !== CW'(2)) begin
         failures++; $display("FAIL chg_count: got %0d want 2", count);
      end
`else
      checks++;
      if (count !== CW'(16)) begin
         failures++; $display("FAIL const_saturate: got %0d want 16", count);
      end
`endif
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== cval) begin
         failures++; $display("FAIL const_data: valid=%b data=%h want %h", rd_valid, rd_data, cval);
      end
      rd_ready = 1'b1;
      for (int j = 0; j < 20 && rd_valid; j++) tick();
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL const_drain: valid=%b busy=%b want 0 0", rd_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_early_trigger();
      test_backpressure();
      test_reset_mid();
      test_ignored();
      test_constant_data();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mips_trace_buffer
